i2s_receiver: RTL

- Deserialises an I2S-style stream (sclk, lrclk, sd) back into parallel left/right samples.
- Is the receive-side counterpart of the team's I2S transmitter. Used for loopback verification and for capturing external ADC/codec audio into the synthesis/effects pipeline.
- The serial inputs are asynchronous and are oversampled in the single system clock domain.
- Emits one left/right sample pair per frame with a single-cycle valid strobe.

---
 rtl/i2s_receiver.sv | 115 +++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// Left-justified I2S deserialiser: oversamples asynchronous sclk/lrclk/sd in the clk
// domain and emits a left/right sample pair with a one-cycle valid strobe per frame.
module i2s_receiver #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             valid,
  output logic             frame_error
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;
  logic rise_det;

  logic             armed;
  logic             last_lr;
  logic             have_left;
  logic             word_done;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] left_hold;
  logic [CW-1:0]    bit_cnt;

  // lrclk and sd use the same depth as sclk so each bit pairs with its own word select
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      lr_s1   <= lrclk;
      lr_s2   <= lr_s1;
      sd_s1   <= sd;
      sd_s2   <= sd_s1;
    end
  end

  assign rise_det = sclk_s2 & ~sclk_s3;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      left_data   <= '0;
      right_data  <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      armed       <= 1'b0;
      have_left   <= 1'b0;
      word_done   <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      left_hold   <= '0;
      last_lr     <= 1'b1;
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
      word_done   <= 1'b0;

      // word_done and rise_det never coincide: sclk edges are at least 4 clk apart
      if (word_done) begin
        if (last_lr) begin
          left_hold <= shift;
          have_left <= 1'b1;
        end else if (have_left) begin
          left_data  <= left_hold;
          right_data <= shift;
          valid      <= 1'b1;
          have_left  <= 1'b0;
        end else begin
          frame_error <= 1'b1;
        end
      end

      if (rise_det) begin
        last_lr <= lr_s2;
        if (!armed) begin
          if (lr_s2 && !last_lr) begin
            armed   <= 1'b1;
            shift   <= {shift[WIDTH-2:0], sd_s2};
            bit_cnt <= CW'(1);
          end
        end else if (lr_s2 != last_lr) begin
          if (bit_cnt != FULL) begin
            frame_error <= 1'b1;
            have_left   <= 1'b0;
          end
          shift   <= {shift[WIDTH-2:0], sd_s2};
          bit_cnt <= CW'(1);
        end else if (bit_cnt < FULL) begin
          shift   <= {shift[WIDTH-2:0], sd_s2};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == FULL - CW'(1))
            word_done <= 1'b1;
        end
      end
    end
  end

endmodule
